// File: rtl/decode_stage.sv
// decode_stage: registered ISSUE_W-lane decoder with two-entry skid buffer (ready/valid)
// Optional feature macro: DECODE_ILLEGAL_EN (flag unrecognised opcodes, squash younger lanes)
// Ports:
//   clk_i, rst_i (async, active-high), flush_i      clock, reset, discard all bundles
//   in_valid_i / in_ready_o                          input bundle handshake
//   in_lane_valid_i, in_instr_i, in_pc_i             fetch bundle (lane 0 oldest, lane k pc = pc+4k)
//   out_valid_o / out_ready_i                        output bundle handshake
//   out_lane_valid_o, out_ctrl_o, out_rd_o,
//   out_rs1_o, out_rs2_o, out_imm_o, out_pc_o,
//   out_illegal_o                                    decoded per-lane fields
// Control words: NOP=0, ALUI=1, ALUR=2, LUI=3, AUIPC=4.
module decode_stage #(
    parameter int ISSUE_W = 2,
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ISSUE_W-1:0]       in_lane_valid_i,
    input  logic [ISSUE_W*XLEN-1:0]  in_instr_i,
    input  logic [XLEN-1:0]          in_pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ISSUE_W-1:0]       out_lane_valid_o,
    output logic [ISSUE_W*CTRL_W-1:0] out_ctrl_o,
    output logic [ISSUE_W*5-1:0]     out_rd_o,
    output logic [ISSUE_W*5-1:0]     out_rs1_o,
    output logic [ISSUE_W*5-1:0]     out_rs2_o,
    output logic [ISSUE_W*XLEN-1:0]  out_imm_o,
    output logic [ISSUE_W*XLEN-1:0]  out_pc_o,
    output logic [ISSUE_W-1:0]       out_illegal_o
);
    localparam logic [6:0] OP_ALUI  = 7'h13;
    localparam logic [6:0] OP_ALUR  = 7'h33;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [CTRL_W-1:0] CTRL_NOP   = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] CTRL_ALUI  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] CTRL_ALUR  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] CTRL_LUI   = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] CTRL_AUIPC = CTRL_W'(4);

    typedef struct packed {
        logic [ISSUE_W-1:0]        lv;
        logic [ISSUE_W*CTRL_W-1:0] ctrl;
        logic [ISSUE_W*5-1:0]      rd;
        logic [ISSUE_W*5-1:0]      rs1;
        logic [ISSUE_W*5-1:0]      rs2;
        logic [ISSUE_W*XLEN-1:0]   imm;
        logic [ISSUE_W*XLEN-1:0]   pc;
        logic [ISSUE_W-1:0]        ill;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state_q;
    bundle_t           or_q;
    bundle_t           sk_q;
    bundle_t           dec;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [XLEN-1:0]   ins_c;
    logic [XLEN-1:0]   imm_c;
    logic [CTRL_W-1:0] ctl_c;
    logic              lv_c;
`ifdef DECODE_ILLEGAL_EN
    logic              kill_c;
`endif

    always_comb begin
        dec = '0;
        ins_c = '0;
        imm_c = '0;
        ctl_c = CTRL_NOP;
        lv_c = 1'b0;
`ifdef DECODE_ILLEGAL_EN
        kill_c = 1'b0;
`endif
        for (int k = 0; k < ISSUE_W; k++) begin
            ins_c = in_instr_i[k*XLEN +: XLEN];
            ctl_c = ins_c[6:0] == OP_ALUI  ? CTRL_ALUI  :
                    ins_c[6:0] == OP_ALUR  ? CTRL_ALUR  :
                    ins_c[6:0] == OP_LUI   ? CTRL_LUI   :
                    ins_c[6:0] == OP_AUIPC ? CTRL_AUIPC : CTRL_NOP;
            imm_c = ctl_c == CTRL_ALUI ? XLEN'($signed(ins_c[31:20])) :
                    (ctl_c == CTRL_LUI || ctl_c == CTRL_AUIPC) ? XLEN'($signed({ins_c[31:12], 12'b0})) : '0;
`ifdef DECODE_ILLEGAL_EN
            // the first illegal lane squashes every younger lane of its bundle
            lv_c = in_lane_valid_i[k] & ~kill_c;
            dec.ill[k] = lv_c & (ctl_c == CTRL_NOP);
            kill_c = kill_c | dec.ill[k];
`else
            lv_c = in_lane_valid_i[k];
`endif
            dec.lv[k] = lv_c;
            dec.ctrl[k*CTRL_W +: CTRL_W] = lv_c ? ctl_c : CTRL_NOP;
            dec.imm[k*XLEN +: XLEN] = lv_c ? imm_c : '0;
            dec.rd[k*5 +: 5] = ins_c[11:7];
            dec.rs1[k*5 +: 5] = ins_c[19:15];
            dec.rs2[k*5 +: 5] = ins_c[24:20];
            dec.pc[k*XLEN +: XLEN] = in_pc_i + XLEN'(4 * k);
        end
    end

    // in_ready is a flop so issue-side backpressure never reaches fetch combinationally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            or_q <= '0;
            sk_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (flush_i) begin
            state_q <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (in_valid_i) begin
                    or_q <= dec;
                    state_q <= ONE;
                    out_valid_q <= 1'b1;
                end
                ONE: if (in_valid_i && out_ready_i) begin
                    or_q <= dec;
                end else if (in_valid_i) begin
                    sk_q <= dec;
                    state_q <= FULL;
                    in_ready_q <= 1'b0;
                end else if (out_ready_i) begin
                    state_q <= EMPTY;
                    out_valid_q <= 1'b0;
                end
                FULL: if (out_ready_i) begin
                    or_q <= sk_q;
                    state_q <= ONE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o       = in_ready_q;
    assign out_valid_o      = out_valid_q;
    assign out_lane_valid_o = or_q.lv;
    assign out_ctrl_o       = or_q.ctrl;
    assign out_rd_o         = or_q.rd;
    assign out_rs1_o        = or_q.rs1;
    assign out_rs2_o        = or_q.rs2;
    assign out_imm_o        = or_q.imm;
    assign out_pc_o         = or_q.pc;
    assign out_illegal_o    = or_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table, directed handshake sequences and random traffic vs. a queue model
module tb_decode_stage;
    localparam int W  = 2;
    localparam int XL = 32;
    localparam int CW = 4;
    localparam logic [CW-1:0] C_NOP = 4'd0, C_ALUI = 4'd1, C_ALUR = 4'd2, C_LUI = 4'd3, C_AUIPC = 4'd4;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_lv, out_lv, out_ill;
    logic [W*XL-1:0] in_instr, out_imm, out_pc;
    logic [XL-1:0] in_pc;
    logic [W*CW-1:0] out_ctrl;
    logic [W*5-1:0] out_rd, out_rs1, out_rs2;

    int checks = 0;
    int errors = 0;

    decode_stage #(.ISSUE_W(W), .XLEN(XL), .CTRL_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_lane_valid_i(in_lv), .in_instr_i(in_instr), .in_pc_i(in_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_lane_valid_o(out_lv), .out_ctrl_o(out_ctrl),
        .out_rd_o(out_rd), .out_rs1_o(out_rs1), .out_rs2_o(out_rs2),
        .out_imm_o(out_imm), .out_pc_o(out_pc), .out_illegal_o(out_ill)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]         lv;
        logic [W-1:0]         ill;
        logic [W-1:0][CW-1:0] ctrl;
        logic [W-1:0][4:0]    rd;
        logic [W-1:0][4:0]    rs1;
        logic [W-1:0][4:0]    rs2;
        logic [W-1:0][31:0]   imm;
        logic [W-1:0][31:0]   pc;
    } bun_t;

    bun_t q[$];

    typedef struct {
        logic [W-1:0] lv;
        logic [31:0]  i0, i1, pc;
        logic [W-1:0] elv, eill;
        logic [CW-1:0] ec0, ec1;
        logic [31:0]  ei0, ei1, epc1;
        logic [4:0]   erd0, erd1;
    } vec_t;

    vec_t tbl[7];

    function automatic bun_t model(input logic [W-1:0] lv, input logic [W*XL-1:0] ins, input logic [31:0] pc);
        bun_t b;
        logic kill;
        logic [31:0] i;
        b = '0;
        kill = 1'b0;
        for (int k = 0; k < W; k++) begin
            i = ins[k*XL +: XL];
            b.rd[k] = i[11:7];
            b.rs1[k] = i[19:15];
            b.rs2[k] = i[24:20];
            b.pc[k] = pc + 32'(4 * k);
            b.lv[k] = lv[k] & ~kill;
            if (b.lv[k]) begin
                case (i[6:0])
                    7'h13: begin b.ctrl[k] = C_ALUI; b.imm[k] = 32'($signed(i[31:20])); end
                    7'h33: b.ctrl[k] = C_ALUR;
                    7'h37: begin b.ctrl[k] = C_LUI; b.imm[k] = i & 32'hFFFFF000; end
                    7'h17: begin b.ctrl[k] = C_AUIPC; b.imm[k] = i & 32'hFFFFF000; end
                    default: begin
`ifdef DECODE_ILLEGAL_EN
                        b.ill[k] = 1'b1;
                        kill = 1'b1;
`endif
                    end
                endcase
            end
        end
        return b;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        logic [6:0] ops[6];
        ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h7F, 7'h03};
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 5)];
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic check_out(input string tag);
        bun_t e;
        logic [84:0] a, x;
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0 && out_valid) begin
            e = q[0];
            for (int k = 0; k < W; k++) begin
                if (e.lv[k]) begin
                    a = {out_lv[k], out_ctrl[k*CW +: CW], out_rd[k*5 +: 5], out_rs1[k*5 +: 5], out_rs2[k*5 +: 5],
                         out_imm[k*XL +: XL], out_pc[k*XL +: XL], out_ill[k]};
                    x = {1'b1, e.ctrl[k], e.rd[k], e.rs1[k], e.rs2[k], e.imm[k], e.pc[k], e.ill[k]};
                end else begin
                    a = 85'({out_lv[k], out_ctrl[k*CW +: CW], out_ill[k]});
                    x = 85'({1'b0, C_NOP, 1'b0});
                end
                checks++;
                if (a !== x) begin
                    errors++;
                    $display("FAIL %s lane%0d: got %h expected %h", tag, k, a, x);
                end
            end
        end
    endtask

    // one clock: drive at the negedge, advance the model as of the next posedge, check at the following negedge
    task automatic cyc(input logic v, input logic [W-1:0] lv, input logic [W*XL-1:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input string tag);
        logic take;
        in_valid = v;
        in_lv = lv;
        in_instr = ins;
        in_pc = pc;
        out_ready = ordy;
        flush = fl;
        take = v && q.size() < 2;
        if (fl) q.delete();
        else begin
            if (ordy && q.size() > 0) void'(q.pop_front());
            if (take) q.push_back(model(lv, ins, pc));
        end
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic idle(input logic ordy, input string tag);
        cyc(1'b0, '0, '0, '0, ordy, 1'b0, tag);
    endtask

    task automatic rnd_bundle(input logic ordy, input string tag);
        cyc(1'b1, W'($urandom()), {rnd_instr(), rnd_instr()}, $urandom(), ordy, 1'b0, tag);
    endtask

    initial begin
        tbl[0] = '{2'b11, 32'hFFF00093, 32'h12345137, 32'h100, 2'b11, 2'b00, C_ALUI, C_LUI, 32'hFFFFFFFF, 32'h12345000, 32'h104, 5'd1, 5'd2};
        tbl[1] = '{2'b11, 32'hFFF00093, 32'h12345137, 32'hFFFFFFFC, 2'b11, 2'b00, C_ALUI, C_LUI, 32'hFFFFFFFF, 32'h12345000, 32'h0, 5'd1, 5'd2};
        tbl[2] = '{2'b11, 32'h002081B3, 32'h80000297, 32'h1000, 2'b11, 2'b00, C_ALUR, C_AUIPC, 32'h0, 32'h80000000, 32'h1004, 5'd3, 5'd5};
        tbl[3] = '{2'b01, 32'h00500093, 32'h12345137, 32'h20, 2'b01, 2'b00, C_ALUI, C_NOP, 32'h5, 32'h0, 32'h24, 5'd1, 5'd2};
        tbl[4] = '{2'b00, 32'hFFF00093, 32'h12345137, 32'h40, 2'b00, 2'b00, C_NOP, C_NOP, 32'h0, 32'h0, 32'h44, 5'd1, 5'd2};
`ifdef DECODE_ILLEGAL_EN
        tbl[5] = '{2'b11, 32'h0000007F, 32'h00500093, 32'h300, 2'b01, 2'b01, C_NOP, C_NOP, 32'h0, 32'h0, 32'h304, 5'd0, 5'd1};
`else
        tbl[5] = '{2'b11, 32'h0000007F, 32'h00500093, 32'h300, 2'b11, 2'b00, C_NOP, C_ALUI, 32'h0, 32'h5, 32'h304, 5'd0, 5'd1};
`endif
        tbl[6] = '{2'b11, 32'h7FF00093, 32'h80000093, 32'h200, 2'b11, 2'b00, C_ALUI, C_ALUI, 32'h7FF, 32'hFFFFF800, 32'h204, 5'd1, 5'd1};

        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_lv = '0;
        in_instr = '0;
        in_pc = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_data", 64'(|{out_lv, out_ctrl, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_ill}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[n]) begin
            cyc(1'b1, tbl[n].lv, {tbl[n].i1, tbl[n].i0}, tbl[n].pc, 1'b1, 1'b0, $sformatf("tv%0d", n));
            chk($sformatf("tv%0d_lv", n), 64'(out_lv), 64'(tbl[n].elv));
            chk($sformatf("tv%0d_ill", n), 64'(out_ill), 64'(tbl[n].eill));
            chk($sformatf("tv%0d_ctrl", n), 64'(out_ctrl), 64'({tbl[n].ec1, tbl[n].ec0}));
            chk($sformatf("tv%0d_rd", n), 64'(out_rd), 64'({tbl[n].erd1, tbl[n].erd0}));
            chk($sformatf("tv%0d_pc1", n), 64'(out_pc[XL +: XL]), 64'(tbl[n].epc1));
            if (tbl[n].elv[0]) chk($sformatf("tv%0d_imm0", n), 64'(out_imm[0 +: XL]), 64'(tbl[n].ei0));
            if (tbl[n].elv[1]) chk($sformatf("tv%0d_imm1", n), 64'(out_imm[XL +: XL]), 64'(tbl[n].ei1));
        end
        idle(1'b1, "drain0");

        for (int n = 0; n < 10; n++) rnd_bundle(1'b1, "stream");
        idle(1'b1, "drain1");

        for (int n = 0; n < 3; n++) rnd_bundle(1'b0, "bp");
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        for (int n = 0; n < 4; n++) rnd_bundle(1'b1, "bp_release");
        idle(1'b1, "drain2");
        idle(1'b1, "drain3");

        rnd_bundle(1'b0, "fl_fill");
        rnd_bundle(1'b0, "fl_fill");
        chk("fl_full_in_ready", 64'(in_ready), 64'd0);
        cyc(1'b1, 2'b11, {32'h00100093, 32'h00200113}, 32'h500, 1'b0, 1'b1, "flush");
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        idle(1'b1, "post_flush");
        idle(1'b1, "post_flush");

        rnd_bundle(1'b0, "rst_fill");
        rnd_bundle(1'b0, "rst_fill");
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_ctrl", 64'(out_ctrl), 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1, "post_rst");

        for (int n = 0; n < 400; n++)
            cyc($urandom_range(0, 3) != 0, W'($urandom()), {rnd_instr(), rnd_instr()}, $urandom(),
                $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, "rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered multi-lane decode stage for the dual-issue core. Accepts a fetch bundle of `ISSUE_W` instructions per cycle, produces per-lane control words, register indices and sign-extended immediates, and presents them to issue through a ready/valid handshake. A two-deep skid buffer keeps throughput at one bundle per cycle under backpressure. It sits between the fetch queue and issue/register-read, replacing the purely combinational opcode decoder.

## Interface
- `ISSUE_W`, 2: number of decode lanes (1..4); lane 0 is oldest.
- `XLEN`, 32: instruction and immediate width.
- `CTRL_W`, width of `CTRL_BUS` from `src/defs.v`: per-lane control word width.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `flush_i`  in  1  discard all held and incoming bundles.
- `in_valid_i`  in  1  input bundle valid.
- `in_ready_o`  out  1  stage can accept a bundle this cycle.
- `in_lane_valid_i`  in  ISSUE_W  per-lane valid within bundle.
- `in_instr_i`  in  ISSUE_W*XLEN  instructions, lane k at bits [k*XLEN +: XLEN].
- `in_pc_i`  in  XLEN  PC of lane 0; lane k PC = in_pc_i + 4k.
- `out_valid_o`  out  1  output bundle valid.
- `out_ready_i`  in  1  issue accepts output bundle.
- `out_lane_valid_o`  out  ISSUE_W  per-lane valid.
- `out_ctrl_o`  out  ISSUE_W*CTRL_W  control words (`ALUI_CTRL`, `ALUR_CTRL`, `LUI_CTRL`, `AUIPC_CTRL`, else `NOP`).
- `out_rd_o`, `out_rs1_o`, `out_rs2_o`  out  ISSUE_W*5 each  register fields.
- `out_imm_o`  out  ISSUE_W*XLEN  sign-extended immediate.
- `out_pc_o`  out  ISSUE_W*XLEN  per-lane PC.
- `out_illegal_o`  out  ISSUE_W  per-lane illegal flag (only with `DECODE_ILLEGAL_EN`; else tied 0).

## Operation
- Decode per lane by opcode [6:0]: ALUI → I-imm (instr[31:20] sign-extended); ALUR → imm 0; LUI/AUIPC → U-imm {instr[31:12],12'b0}; other → `NOP`, imm 0.
- rd/rs1/rs2 taken from instr[11:7]/[19:15]/[24:20] for every lane regardless of opcode; lanes with lane-valid 0 output `NOP` ctrl.
- PC arithmetic modulo 2^XLEN (wrap silently).
- Storage: output register (OR) + skid register (SK), each with a valid bit.
- Transfer in: `in_valid_i & in_ready_o`. Transfer out: `out_valid_o & out_ready_i`.
- `in_ready_o = ~SK.valid` (registered state, no combinational path from `out_ready_i`).
- States: EMPTY (OR, SK invalid), ONE (OR valid), FULL (both valid).
  - EMPTY + in → ONE.
  - ONE + in & out → ONE (new bundle into OR); ONE + in & ~out → FULL (new into SK); ONE + out & ~in → EMPTY.
  - FULL + out → ONE (SK moves to OR); `in_ready_o`=0 so no input accepted.
- `flush_i`: next state EMPTY; overrides any simultaneous input or output transfer; incoming bundle dropped.
- Input bundle with `in_lane_valid_i`=0 and `in_valid_i`=1: accepted, passed with all lanes invalid.

## Timing
- Latency: 1 cycle input-accept → `out_valid_o`.
- Throughput: 1 bundle/cycle while `out_ready_i`=1.
- Output data stable while `out_valid_o`=1 and `out_ready_i`=0.
- Reset values: `out_valid_o`=0, `in_ready_o`=1, all lane valids 0, ctrl=`NOP`, rd/rs/imm/pc/illegal=0.
- Reset asserted mid-operation: all state cleared immediately (async), bundles lost.

## Configuration
- `DECODE_ILLEGAL_EN` defined: lane with valid=1 and unrecognised opcode gets `out_illegal_o`=1, ctrl `NOP`; all younger lanes in that bundle have lane-valid forced 0. Illegal flag travels through SK with its bundle.
- Undefined: unrecognised opcodes decode silently to `NOP`, younger lanes unaffected, `out_illegal_o` constant 0.

## Test plan
- Reset: assert `rst_i` mid-FULL → same cycle `out_valid_o`=0, `in_ready_o`=1, ctrl=`NOP`.
- Streaming: lanes {addi x1,x0,-1 ; lui x2,0x12345}, pc 0x100, out_ready=1 → next cycle lane0 ALUI imm 0xFFFFFFFF rd 1 pc 0x100; lane1 LUI imm 0x12345000 rd 2 pc 0x104; one bundle/cycle for 10 back-to-back bundles.
- Backpressure: out_ready=0 for 3 cycles while streaming → FULL after 2 accepts, `in_ready_o`=0, no loss/duplication, order preserved on release.
- Flush: in FULL, `flush_i`=1 with in_valid=1 → next cycle EMPTY, `out_valid_o`=0, flushed bundle never appears.
- PC wrap: in_pc 0xFFFFFFFC → lane1 pc 0x00000000.
- `DECODE_ILLEGAL_EN`: lane0 opcode 0x7F, lane1 addi → lane0 illegal=1 ctrl `NOP`, lane1 valid 0; without macro lane1 valid 1, illegal 0.
